// File: rtl/tinyqv_uart_tx_fifo.sv
// Buffered debug UART transmitter for the tinyQV peripheral bus: byte FIFO,
// programmable divider and stop bits, and a registered low-water interrupt.
module tinyqv_uart_tx_fifo #(
    parameter int CLOCK_MHZ  = 64,
    parameter int FIFO_DEPTH = 8,
    parameter int DIV_WIDTH  = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  addr_in,
    input  logic [31:0] data_in,
    input  logic [1:0]  data_write_n,
    input  logic [1:0]  data_read_n,
    output logic [31:0] data_out,
    output logic        data_ready,
    output logic        uart_txd,
    output logic        irq
);
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int LW = $clog2(FIFO_DEPTH + 1);
    localparam logic [DIV_WIDTH-1:0] DIV_RESET = DIV_WIDTH'(CLOCK_MHZ / 4 - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    logic [7:0]           fifo_q [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]        level_q, level_d;
    logic                 overflow_q, overflow_d;
    logic [DIV_WIDTH-1:0] divider_q, divider_d;
    logic                 enable_q, enable_d, two_stop_q, two_stop_d, irq_en_q, irq_en_d;
    logic [7:0]           thresh_q, thresh_d;
    state_t               state_q, state_d;
    logic [7:0]           shift_q, shift_d;
    logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
    logic [2:0]           bit_q, bit_d;
    logic                 txd_q, txd_d, irq_q, irq_d;

    logic       wr_en, push, pop, push_ok, full, empty, busy, bit_end;
    logic [1:0] sel;
    logic [7:0] level8;
    logic       unused_bits;

    assign sel         = addr_in[3:2];
    assign wr_en       = data_write_n != 2'b11;
    assign full        = level_q == LW'(FIFO_DEPTH);
    assign empty       = level_q == '0;
    assign busy        = (state_q != IDLE) || !empty;
    assign level8      = 8'(level_q);
    assign push        = wr_en && sel == 2'd0;
    assign pop         = state_q == IDLE && enable_q && !empty;
    // A pop frees the head slot this cycle, so a push to a full FIFO still fits.
    assign push_ok     = push && (!full || pop);
    assign bit_end     = cnt_q == '0;
    assign data_ready  = 1'b1;
    assign uart_txd    = txd_q;
    assign irq         = irq_q;
    assign unused_bits = ^{data_read_n, addr_in[1:0], data_in};

    always_comb begin
        data_out = 32'h0;
        case (sel)
            2'd0: data_out = {24'h0, level8};
            2'd1: data_out = {16'h0, level8, 4'h0, overflow_q, empty, full, busy};
            2'd2: data_out = 32'(divider_q);
            2'd3: data_out = {15'h0, irq_en_q, thresh_q, 6'h0, two_stop_q, enable_q};
        endcase
    end

    always_comb begin
        wr_ptr_d   = push_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d   = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
        level_d    = level_q;
        if (push_ok && !pop)      level_d = level_q + LW'(1);
        else if (!push_ok && pop) level_d = level_q - LW'(1);
        overflow_d = overflow_q;
        if (wr_en && sel == 2'd1 && data_in[3]) overflow_d = 1'b0;
        if (push && !push_ok)                   overflow_d = 1'b1;
        divider_d  = (wr_en && sel == 2'd2) ? data_in[DIV_WIDTH-1:0] : divider_q;
        enable_d   = enable_q;
        two_stop_d = two_stop_q;
        thresh_d   = thresh_q;
        irq_en_d   = irq_en_q;
        if (wr_en && sel == 2'd3) begin
            enable_d   = data_in[0];
            two_stop_d = data_in[1];
            thresh_d   = data_in[15:8];
            irq_en_d   = data_in[16];
        end
        irq_d = irq_en_q && (32'(level_q) <= 32'(thresh_q));
    end

    // Bit timer counts DIVIDER..0; each boundary reloads from the live divider.
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        cnt_d   = bit_end ? cnt_q : cnt_q - DIV_WIDTH'(1);
        bit_d   = bit_q;
        txd_d   = txd_q;
        case (state_q)
            IDLE: begin
                txd_d = 1'b1;
                if (pop) begin
                    state_d = START;
                    shift_d = fifo_q[rd_ptr_q];
                    cnt_d   = divider_q;
                    txd_d   = 1'b0;
                end
            end
            START: if (bit_end) begin
                state_d = DATA;
                cnt_d   = divider_q;
                bit_d   = 3'd0;
                txd_d   = shift_q[0];
            end
            DATA: if (bit_end) begin
                cnt_d = divider_q;
                if (bit_q == 3'd7) begin
                    state_d = STOP;
                    bit_d   = 3'd0;
                    txd_d   = 1'b1;
                end else begin
                    shift_d = shift_q >> 1;
                    bit_d   = bit_q + 3'd1;
                    txd_d   = shift_q[1];
                end
            end
            STOP: if (bit_end) begin
                if (two_stop_q && bit_q == 3'd0) begin
                    bit_d = 3'd1;
                    cnt_d = divider_q;
                end else begin
                    state_d = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (push_ok) fifo_q[wr_ptr_q] <= data_in[7:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
            divider_q  <= DIV_RESET;
            enable_q   <= 1'b1;
            two_stop_q <= 1'b0;
            thresh_q   <= 8'h0;
            irq_en_q   <= 1'b0;
            state_q    <= IDLE;
            shift_q    <= 8'h0;
            cnt_q      <= '0;
            bit_q      <= 3'd0;
            txd_q      <= 1'b1;
            irq_q      <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            overflow_q <= overflow_d;
            divider_q  <= divider_d;
            enable_q   <= enable_d;
            two_stop_q <= two_stop_d;
            thresh_q   <= thresh_d;
            irq_en_q   <= irq_en_d;
            state_q    <= state_d;
            shift_q    <= shift_d;
            cnt_q      <= cnt_d;
            bit_q      <= bit_d;
            txd_q      <= txd_d;
            irq_q      <= irq_d;
        end
    end
endmodule
